// File: rtl/alu_issue_pkg.sv
// Shared FSM state type, ALU opcode encodings and default sizing for the ALU issue queue.
package alu_issue_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CMD_W_DEF  = 4;

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_SUB  = 4'b0001;
  localparam logic [3:0] CMD_MUL  = 4'b1101;
  localparam logic [3:0] CMD_BUFF = 4'b1110;
  localparam logic [3:0] CMD_INVR = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Request (in_*) and result (out_*) valid/ready channels of the ALU issue queue.
// master = producer/consumer side, slave = the queue.
interface alu_issue_queue_if import alu_issue_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CMD_W  = CMD_W_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_a;
  logic [DATA_W-1:0]     in_b;
  logic [CMD_W-1:0]      in_cmd;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_res;
  logic [CMD_W-1:0]      out_cmd;

  modport master (
    output in_valid, in_a, in_b, in_cmd, out_ready,
    input  in_ready, out_valid, out_res, out_cmd
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cmd, out_ready,
    output in_ready, out_valid, out_res, out_cmd
  );
endinterface

// File: rtl/alu_issue_queue_sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth; head visible on rdata, push/pop take effect at the edge.
// Push ignored when full, pop ignored when empty; count is the registered occupancy.
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_issue_queue.sv
// Queues ALU requests and issues them one at a time; accept->out_valid 2 cycles (1 with ALU_ISSUE_BYPASS_EN).
// in_ready drops at DEPTH queued entries; a result is held stable until out_ready.
module alu_issue_queue import alu_issue_pkg::*; #(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CMD_W  = CMD_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_issue_queue_if.slave       io,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [CMD_W-1:0]       alu_cmd,
  output logic                   alu_en,
  input  logic [2*DATA_W-1:0]    alu_res,
  output logic [$clog2(DEPTH):0] count
);
  localparam int ENT_W = 2*DATA_W + CMD_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [2*DATA_W-1:0]   out_res_q, out_res_d;
  logic [CMD_W-1:0]      out_cmd_q, out_cmd_d;
  logic [ENT_W-1:0]      head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push, pop;

  // Registered occupancy only: a pop in the same cycle never opens the input.
  assign io.in_ready = (fifo_count < CNT_W'(DEPTH));
  assign push        = io.in_valid && io.in_ready;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({io.in_a, io.in_b, io.in_cmd}),
    .rdata (head),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_cmd_d   = out_cmd_q;
    pop         = 1'b0;
    alu_en      = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_cmd     = '0;
    case (state_q)
      IDLE: begin
`ifdef ALU_ISSUE_BYPASS_EN
        // The accepted entry lands at the head of an empty FIFO, so it can issue next cycle.
        if (fifo_count != '0 || push) state_d = ISSUE;
`else
        if (fifo_count != '0) state_d = ISSUE;
`endif
      end
      ISSUE: begin
        alu_en                  = 1'b1;
        {alu_a, alu_b, alu_cmd} = head;
        pop                     = 1'b1;
        out_res_d               = alu_res;
        out_cmd_d               = head[CMD_W-1:0];
        out_valid_d             = 1'b1;
        state_d                 = HOLD;
      end
      HOLD: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (fifo_count != '0) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_cmd_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_cmd_q   <= out_cmd_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_res   = out_res_q;
  assign io.out_cmd   = out_cmd_q;
  assign count        = fifo_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed bench for alu_issue_queue against a queue-level reference model.
// Expected latency follows ALU_ISSUE_BYPASS_EN.
module tb_alu_issue_queue;
  import alu_issue_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int CMD_W  = 4;
`ifdef ALU_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] cmd;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_en;
  logic [15:0] alu_res;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  req_t        acc_q[$];
  logic [19:0] res_q[$];

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DATA_W(DATA_W), .CMD_W(CMD_W)) io ();

  alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CMD_W(CMD_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io      (io),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_cmd (alu_cmd),
    .alu_en  (alu_en),
    .alu_res (alu_res),
    .count   (count)
  );

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    case (c)
      4'd0:    return {8'd0, a} + {8'd0, b};
      4'd1:    return {8'd0, a} - {8'd0, b};
      4'd13:   return 16'(a) * 16'(b);
      4'd14:   return {8'd0, a};
      4'd15:   return {8'd0, ~a};
      default: return {a ^ b, b ^ {4'd0, c}};
    endcase
  endfunction

  // ALU stand-in; a recognisable junk value when disabled exposes any sampling outside ISSUE.
  assign alu_res = alu_en ? alu_fn(alu_a, alu_b, alu_cmd) : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted requests wait in acc_q until seen on the ALU, then their results wait in res_q.
  logic        prev_hold = 1'b0;
  logic [19:0] prev_out;
  req_t        mon_r;
  logic [19:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      res_q.delete();
      prev_hold = 1'b0;
    end else begin
      chk("count", 32'(count), 32'(acc_q.size()));
      chk("in_ready", 32'(io.in_ready), 32'(acc_q.size() < DEPTH));
      if (prev_hold) begin
        chk("hold_valid", 32'(io.out_valid), 32'd1);
        chk("hold_stable", 32'({io.out_cmd, io.out_res}), 32'(prev_out));
      end
      if (io.out_valid && io.out_ready) begin
        n_out++;
        if (res_q.size() == 0) chk("out_unexpected", 32'(io.out_res), 32'hFFFF_FFFF);
        else begin
          mon_e = res_q.pop_front();
          chk("out_data", 32'({io.out_cmd, io.out_res}), 32'(mon_e));
        end
      end
      if (alu_en) begin
        chk("issue_while_hold", 32'(io.out_valid), 32'd0);
        if (acc_q.size() == 0) chk("issue_empty", 32'(alu_en), 32'd0);
        else begin
          mon_r = acc_q.pop_front();
          chk("issue_ops", 32'({alu_cmd, alu_a, alu_b}), 32'({mon_r.cmd, mon_r.a, mon_r.b}));
          res_q.push_back({mon_r.cmd, alu_fn(mon_r.a, mon_r.b, mon_r.cmd)});
        end
      end else begin
        chk("alu_idle_zero", 32'({alu_cmd, alu_a, alu_b}), 32'd0);
      end
      if (io.in_valid && io.in_ready) begin
        mon_r.a   = io.in_a;
        mon_r.b   = io.in_b;
        mon_r.cmd = io.in_cmd;
        acc_q.push_back(mon_r);
      end
      prev_hold = io.out_valid && !io.out_ready;
      prev_out  = {io.out_cmd, io.out_res};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    io.in_cmd   = c;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    while ((acc_q.size() != 0 || res_q.size() != 0 || io.out_valid) && t < 300) begin
      tick();
      t++;
    end
    chk(tag, 32'(acc_q.size() + res_q.size()), 32'd0);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int   lat, en_cyc, t0, t1, k, n_out0, seen;
    logic acc, found;
    req_t first;

    io.in_valid = 1'b0; io.in_a = '0; io.in_b = '0; io.in_cmd = '0; io.out_ready = 1'b0;

    // Asynchronous reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_out_res", 32'(io.out_res), 32'd0);
    chk("rst_out_cmd", 32'(io.out_cmd), 32'd0);
    chk("rst_alu", 32'({alu_en, alu_cmd, alu_a, alu_b}), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Single ADD: latency and one-cycle alu_en
    io.out_ready = 1'b1;
    drive_req(8'd10, 8'd5, CMD_ADD);
    tick();
    io.in_valid = 1'b0;
    lat = -1; en_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (alu_en) en_cyc++;
      if (io.out_valid && lat < 0) begin
        lat = i;
        chk("add_res", 32'(io.out_res), 32'h000F);
        chk("add_cmd", 32'(io.out_cmd), 32'(CMD_ADD));
      end
    end
    chk("add_latency", 32'(lat), 32'(LAT));
    chk("add_en_cycles", 32'(en_cyc), 32'd1);
    drain("drain_add");

    // MUL then SUB back to back
    drive_req(8'd4, 8'd2, CMD_MUL);
    tick();
    drive_req(8'd10, 8'd5, CMD_SUB);
    tick();
    io.in_valid = 1'b0;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (io.out_valid && io.out_ready) begin
        if (t0 < 0) begin
          t0 = i;
          chk("mul_res", 32'(io.out_res), 32'h0008);
        end else if (t1 < 0) begin
          t1 = i;
          chk("sub_res", 32'(io.out_res), 32'h0005);
        end
      end
    end
    chk("b2b_spacing", 32'(t1 - t0), 32'd2);
    drain("drain_b2b");

    // Backpressure: six offered, five fit (four queued plus one held)
    n_out0 = n_out;
    io.out_ready = 1'b0;
    first.a = 8'($urandom); first.b = 8'($urandom); first.cmd = 4'($urandom);
    drive_req(first.a, first.b, first.cmd);
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = io.in_ready;
      tick();
      if (acc) begin
        k++;
        drive_req(8'($urandom), 8'($urandom), 4'($urandom));
      end
    end
    @(negedge clk);
    chk("bp_accepted", 32'(k), 32'd5);
    chk("bp_in_ready", 32'(io.in_ready), 32'd0);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_held_res", 32'({io.out_valid, io.out_cmd, io.out_res}),
        32'({1'b1, first.cmd, alu_fn(first.a, first.b, first.cmd)}));

    // Full with pop: no push while the pop happens, in_ready rises after it
    tick();
    io.out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (alu_en) begin
        found = 1'b1;
        chk("fp_pop_in_ready", 32'(io.in_ready), 32'd0);
        chk("fp_pop_count", 32'(count), 32'd4);
      end
    end
    chk("fp_issue_seen", 32'(found), 32'd1);
    @(negedge clk);
    chk("fp_after_in_ready", 32'(io.in_ready), 32'd1);
    chk("fp_after_count", 32'(count), 32'd3);
    tick();
    io.in_valid = 1'b0;
    drain("drain_bp");
    chk("bp_outputs", 32'(n_out - n_out0), 32'd6);

    // Reset while holding a result with three queued
    io.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(8'($urandom), 8'($urandom), 4'($urandom));
      tick();
    end
    io.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_out_valid", 32'(io.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_alu_en", 32'(alu_en), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    io.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (io.out_valid || alu_en) seen++;
    end
    chk("no_stale", 32'(seen), 32'd0);
    tick();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      io.in_valid  = ($urandom_range(0, 2) != 0);
      io.in_a      = 8'($urandom);
      io.in_b      = 8'($urandom);
      io.in_cmd    = 4'($urandom_range(0, 15));
      io.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("drain_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
